uart_mmio: RTL and testbench

Memory-mapped full-duplex UART peripheral; the parametrised successor to the TX-only uartwriter plus external FIFO pair. Integrates a TX FIFO, an RX FIFO, a TX serialiser, an RX oversampling deserialiser and a runtime-programmable baud divisor behind a small register window. Sits behind memmap as one slave region, driven by the core's address/data/write bus.

---
 rtl/uart_mmio.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
// uart_mmio: memory-mapped full-duplex UART with TX/RX FIFOs, a runtime baud divisor and a
// 4-word register window. Define UART_MMIO_IRQ_EN to add the IRQ_EN register and the o_irq output.
module uart_mmio #(
  parameter int DATA_WIDTH      = 32,
  parameter int TX_DEPTH_LOG2   = 4,
  parameter int RX_DEPTH_LOG2   = 4,
  parameter int DIV_WIDTH       = 16,
  parameter int CLK_DIV_DEFAULT = 434
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_write,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_rdata,
`ifdef UART_MMIO_IRQ_EN
  output logic                  o_irq,
`endif
  input  logic                  i_rx,
  output logic                  o_tx
);

  localparam int TXA = TX_DEPTH_LOG2;
  localparam int RXA = RX_DEPTH_LOG2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic wr_data, wr_div, rd_data, rd_status, unused_wdata;
  assign wr_data      = i_write && (i_addr == 2'd0);
  assign wr_div       = i_write && (i_addr == 2'd2);
  assign rd_data      = i_read  && (i_addr == 2'd0);
  assign rd_status    = i_read  && (i_addr == 2'd1);
  assign unused_wdata = ^i_wdata;

  logic [DIV_WIDTH-1:0] div_q, div_wr;
  assign div_wr = i_wdata[DIV_WIDTH-1:0];

  // NOTE: sequential state always uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       div_q <= DIV_WIDTH'(CLK_DIV_DEFAULT);
    else if (wr_div) div_q <= (div_wr < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_wr;
  end

  // ---------------- TX FIFO + serialiser ----------------
  logic [7:0]     tx_mem [2**TXA];
  logic [TXA:0]   tx_wptr, tx_rptr;
  logic           tx_empty, tx_full, tx_push, tx_pop, tx_drop, tx_bit_end;
  tx_state_t      tx_state;
  logic [DIV_WIDTH-1:0] tx_div, tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;

  assign tx_empty   = (tx_wptr == tx_rptr);
  assign tx_full    = (tx_wptr == {~tx_rptr[TXA], tx_rptr[TXA-1:0]});
  assign tx_bit_end = (tx_cnt == tx_div - 1'b1);
  // A pop at the end of STOP chains straight into the next START with no idle bit.
  assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
  assign tx_push = wr_data && (!tx_full || tx_pop);
  assign tx_drop = wr_data && tx_full && !tx_pop;

  // NOTE: FIFO storage has no reset; entries are only ever read behind pointers that are reset.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wptr[TXA-1:0]] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      o_tx     <= 1'b1;
      tx_div   <= DIV_WIDTH'(CLK_DIV_DEFAULT);
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      o_tx     <= 1'b0;
      tx_div   <= div_q;
      tx_cnt   <= '0;
      tx_shift <= tx_mem[tx_rptr[TXA-1:0]];
    end else if (tx_state != TX_IDLE) begin
      if (!tx_bit_end) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            o_tx     <= tx_shift[0];
          end
          TX_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              o_tx     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              o_tx     <= tx_shift[1];
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX synchroniser + deserialiser ----------------
  logic rx_s1, rx_s2, rx_prev;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t            rx_state;
  logic [DIV_WIDTH-1:0] rx_div, rx_cnt;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_shift;
  logic                 rx_bit_end, rx_half_end, rx_push_req, rx_frame_set;

  assign rx_bit_end   = (rx_cnt == rx_div - 1'b1);
  assign rx_half_end  = (rx_cnt == (rx_div >> 1) - 1'b1);
  assign rx_push_req  = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
  assign rx_frame_set = (rx_state == RX_STOP) && rx_bit_end && !rx_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= RX_IDLE;
      rx_div   <= DIV_WIDTH'(CLK_DIV_DEFAULT);
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
          rx_div   <= div_q;
        end
        RX_START: if (rx_half_end) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_bit_end) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_bit_end) begin
          rx_cnt   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: if (rx_s2) rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0]   rx_mem [2**RXA];
  logic [RXA:0] rx_wptr, rx_rptr;
  logic         rx_empty, rx_full, rx_push, rx_pop, rx_drop;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr == {~rx_rptr[RXA], rx_rptr[RXA-1:0]});
  assign rx_pop   = rd_data && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign rx_drop  = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wptr[RXA-1:0]] <= rx_shift;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // ---------------- Sticky flags, status, read port ----------------
  logic rx_overrun, tx_overflow, rx_frame_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_overrun   <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= rx_drop      || (rx_overrun   && !rd_status);
      tx_overflow  <= tx_drop      || (tx_overflow  && !rd_status);
      rx_frame_err <= rx_frame_set || (rx_frame_err && !rd_status);
    end
  end

  logic [7:0] status;
  assign status = {rx_frame_err, tx_overflow, rx_overrun, tx_state != TX_IDLE,
                   rx_full, rx_empty, tx_empty, tx_full};

`ifdef UART_MMIO_IRQ_EN
  logic       wr_irq;
  logic [2:0] irq_en;
  assign wr_irq = i_write && (i_addr == 2'd3);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_en <= '0;
      o_irq  <= 1'b0;
    end else begin
      if (wr_irq) irq_en <= i_wdata[2:0];
      o_irq <= |(irq_en & {rx_overrun | tx_overflow | rx_frame_err, tx_empty, !rx_empty});
    end
  end
`endif

  logic [DATA_WIDTH-1:0] rd_mux;
  // NOTE: rd_mux gets a default before the case so no path can infer a latch.
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      2'd0: if (!rx_empty) rd_mux = DATA_WIDTH'(rx_mem[rx_rptr[RXA-1:0]]);
      2'd1: rd_mux = DATA_WIDTH'(status);
      2'd2: rd_mux = DATA_WIDTH'(div_q);
`ifdef UART_MMIO_IRQ_EN
      2'd3: rd_mux = DATA_WIDTH'(irq_en);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       o_rdata <= '0;
    else if (i_read) o_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_uart_mmio.sv
`timescale 1ns/1ps
// tb_uart_mmio: directed scoreboard bench for uart_mmio (TX FIFO depth 4, RX FIFO depth 16).
module tb_uart_mmio;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic        i_write, i_read, i_rx;
  logic [31:0] o_rdata;
  logic        o_tx;
`ifdef UART_MMIO_IRQ_EN
  logic        o_irq;
`endif

  always #5 i_clk = ~i_clk;

  uart_mmio #(.TX_DEPTH_LOG2(2)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_write (i_write),
    .i_read  (i_read),
    .o_rdata (o_rdata),
`ifdef UART_MMIO_IRQ_EN
    .o_irq   (o_irq),
`endif
    .i_rx    (i_rx),
    .o_tx    (o_tx)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at a negedge, so consecutive calls are back-to-back.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    i_addr = a; i_wdata = d; i_write = 1'b1;
    @(negedge i_clk);
    i_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    i_addr = a; i_read = 1'b1;
    @(negedge i_clk);
    i_read = 1'b0;
    d = o_rdata;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      i_rx = bits[k];
      repeat (div) @(negedge i_clk);
    end
    i_rx = 1'b1;
  endtask

  // Samples o_tx every clock for one frame; skip = samples of this frame already elapsed.
  task automatic tx_frame(input int div, input int max_wait, input int skip);
    logic [7:0] exp;
    logic [9:0] want, got;
    int bad;
    logic found;
    exp   = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    want  = {1'b1, exp, 1'b0};
    got   = '0;
    bad   = 0;
    found = 1'b0;
    if (skip > 0) found = (o_tx === 1'b0);
    else begin
      for (int w = 0; w <= max_wait; w++) begin
        if (o_tx === 1'b0) begin found = 1'b1; break; end
        @(negedge i_clk);
      end
    end
    check("tx_start_seen", found, 1);
    if (found) begin
      for (int i = skip; i < 10 * div; i++) begin
        if (o_tx !== want[i / div]) bad++;
        if ((i % div) == div / 2) got[i / div] = o_tx;
        @(negedge i_clk);
      end
    end
    check("tx_frame", got, want);
    check("tx_bit_timing", bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    i_addr = '0; i_wdata = '0; i_write = 1'b0; i_read = 1'b0; i_rx = 1'b1;
    i_rst = 1'b1;
    wait_clks(3);
    i_rst = 1'b0;

    // Reset state; rx_empty is also set at idle, so the idle STATUS is 0x06.
    check("reset_o_tx", o_tx, 1);
    check("reset_rdata", o_rdata, 0);
    read_check(2'd1, 32'h06, "reset_status");
    read_check(2'd2, 32'd434, "reset_divisor");
    wait_clks(3);
    check("rdata_hold", o_rdata, 32'd434);
    read_check(2'd3, 32'h0, "offset3_reset");
`ifndef UART_MMIO_IRQ_EN
    bus_write(2'd3, 32'h7);
    read_check(2'd3, 32'h0, "offset3_write_ignored");
`endif

    bus_write(2'd2, 32'd1);
    read_check(2'd2, 32'd2, "divisor_clamp");
    bus_write(2'd2, 32'hFFFF_0004);
    read_check(2'd2, 32'd4, "divisor_4");

    // Two back-to-back TX frames at 4 clocks/bit.
    tx_q.push_back(8'h55);
    tx_q.push_back(8'hA3);
    bus_write(2'd0, 32'h55);
    bus_write(2'd0, 32'hA3);
    tx_frame(4, 20, 0);
    tx_frame(4, 0, 0);
    wait_clks(1);
    read_check(2'd1, 32'h06, "status_after_tx");

    // RX byte.
    rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1, 4);
    wait_clks(4);
    read_check(2'd1, 32'h02, "rx_status_nonempty");
    bus_read(2'd0, d);
    check("rx_data", d, {24'h0, rx_q.pop_front()});
    read_check(2'd1, 32'h06, "rx_status_empty");

    // Framing error, then a one-clock glitch.
    rx_frame(8'h81, 1'b0, 4);
    wait_clks(4);
    read_check(2'd1, 32'h86, "frame_err_status");
    read_check(2'd1, 32'h06, "frame_err_cleared");
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rx = 1'b1;
    wait_clks(20);
    read_check(2'd1, 32'h06, "glitch_status");

    // RX overrun: 17 frames into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 37 + 5);
      if (i < 16) rx_q.push_back(b);
      rx_frame(b, 1'b1, 4);
    end
    wait_clks(4);
    read_check(2'd1, 32'h2A, "overrun_status");
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, d);
      check("rx_fifo_data", d, {24'h0, rx_q.pop_front()});
    end
    read_check(2'd1, 32'h06, "overrun_cleared");
    read_check(2'd0, 32'h0, "data_read_empty");

`ifdef UART_MMIO_IRQ_EN
    bus_write(2'd3, 32'h1);
    read_check(2'd3, 32'h1, "irq_en_rw");
    check("irq_idle", o_irq, 0);
    rx_q.push_back(8'h7E);
    rx_frame(8'h7E, 1'b1, 4);
    wait_clks(4);
    check("irq_rx", o_irq, 1);
    bus_read(2'd0, d);
    check("irq_rx_data", d, {24'h0, rx_q.pop_front()});
    wait_clks(1);
    check("irq_cleared", o_irq, 0);
`endif

    // TX overflow with a long divisor; the divisor change only affects later frames.
    bus_write(2'd2, 32'd1000);
    for (int i = 0; i < 6; i++) begin
      b = 8'(8'h11 * (i + 1));
      if (i < 5) tx_q.push_back(b);
      bus_write(2'd0, {24'h0, b});
    end
    read_check(2'd1, 32'h55, "overflow_status");
    read_check(2'd1, 32'h15, "overflow_cleared");
    bus_write(2'd2, 32'd4);
    tx_frame(1000, 0, 7);
    repeat (4) tx_frame(4, 0, 0);
    wait_clks(1);
    read_check(2'd1, 32'h06, "tx_drained");

    // Reset in the middle of a TX frame.
`ifdef UART_MMIO_IRQ_EN
    bus_write(2'd3, 32'h2);
`endif
    bus_write(2'd0, 32'h00);
    wait_clks(12);
    check("tx_mid_frame_low", o_tx, 0);
`ifdef UART_MMIO_IRQ_EN
    check("irq_tx_empty", o_irq, 1);
`endif
    i_rst = 1'b1;
    #1;
    check("rst_o_tx", o_tx, 1);
    check("rst_rdata", o_rdata, 0);
`ifdef UART_MMIO_IRQ_EN
    check("rst_irq", o_irq, 0);
`endif
    @(negedge i_clk);
    i_rst = 1'b0;
    read_check(2'd1, 32'h06, "status_after_rst");
    read_check(2'd2, 32'd434, "divisor_after_rst");
    wait_clks(50);
    check("tx_idle_after_rst", o_tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
